gc_dualrail_driver: RTL



---
 rtl/gc_dualrail_driver.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/gc_dualrail_driver.sv
// -----------------------------------------------------------------------------
// gc_dualrail_driver
//
// Clocked driver that sits on the environment side of the asynchronous genetic
// C-element (gC) block. It turns one single-rail request (sensor, startSignal)
// into a four-phase return-to-zero dual-rail codeword. It waits for the
// dual-rail actuator acknowledge and returns every rail to zero. It then
// reports the decoded actuator value and compares it with a behavioural
// C-element model.
//
// Protocol faults are reported on the sticky err flag until err_clr. The
// faults are an illegal actuator codeword (both rails high) and a phase that
// takes TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT  cycles allowed for each actuator phase before err (>= 4)
//   CNT_W    width of the completed-transaction counter
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (no buffering; in_valid ignored
//                         while in_ready is low)
//   in_sensor, in_start   single-rail request bits
//   sensor_0/1            dual-rail sensor (false/true rail)
//   startSignal_0/1       dual-rail startSignal (false/true rail)
//   actuator_0/1          asynchronous dual-rail acknowledge from the gC block
//   out_valid             one-cycle pulse when a transaction completes
//   out_data              decoded actuator value, valid with out_valid
//   out_mismatch          out_data differs from the C-element model
//   err                   sticky protocol/timeout error
//   err_clr               clears err (only acted on while in the error state)
//   tx_count              completed transactions, wraps
// -----------------------------------------------------------------------------
module gc_dualrail_driver #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sensor,
  input  logic             in_start,
  output logic             sensor_0,
  output logic             sensor_1,
  output logic             startSignal_0,
  output logic             startSignal_1,
  input  logic             actuator_0,
  input  logic             actuator_1,
  output logic             out_valid,
  output logic             out_data,
  output logic             out_mismatch,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] tx_count
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_RTZ,
    ST_DONE,
    ST_ERR
  } state_t;

  // The actuator rails are asynchronous. Each rail has its own two-flop
  // synchronizer, and only the synchronized copies take part in decisions.
  // These flops are deliberately left out of reset so that they keep tracking
  // the gC block. in_ready then reflects the real actuator level straight
  // after reset.
  logic a0_meta_q, a0s_q;
  logic a1_meta_q, a1s_q;

  always_ff @(posedge clk) begin
    a0_meta_q <= actuator_0;
    a0s_q     <= a0_meta_q;
    a1_meta_q <= actuator_1;
    a1s_q     <= a1_meta_q;
  end

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              cap_s_q, cap_s_d;
  logic              cap_t_q, cap_t_d;
  logic              r_q, r_d;
  logic              m_q, m_d;
  logic [CNT_W-1:0]  tx_count_q, tx_count_d;
  logic              in_ready_q, in_ready_d;
  logic              sensor_0_q, sensor_0_d;
  logic              sensor_1_q, sensor_1_d;
  logic              start_0_q, start_0_d;
  logic              start_1_q, start_1_d;
  logic              out_valid_q, out_valid_d;
  logic              out_data_q, out_data_d;
  logic              out_mismatch_q, out_mismatch_d;
  logic              err_q, err_d;

  logic ack_both, ack_one, ack_none, wait_expired, expected;

  always_comb begin
    ack_both     = a0s_q & a1s_q;
    ack_one      = a0s_q ^ a1s_q;
    ack_none     = ~(a0s_q | a1s_q);
    wait_expired = (wcnt_q == WCNT_LAST);
    // C-element model: follow the inputs when they agree, otherwise hold.
    expected     = (cap_s_q == cap_t_q) ? cap_s_q : m_q;

    state_d        = state_q;
    wcnt_d         = wcnt_q;
    cap_s_d        = cap_s_q;
    cap_t_d        = cap_t_q;
    r_d            = r_q;
    m_d            = m_q;
    tx_count_d     = tx_count_q;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    out_mismatch_d = out_mismatch_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          cap_s_d = in_sensor;
          cap_t_d = in_start;
          wcnt_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (ack_both) begin
          state_d = ST_ERR;
        end else if (ack_one) begin
          r_d     = a1s_q;
          wcnt_d  = '0;
          state_d = ST_RTZ;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_RTZ: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (ack_both) begin
          state_d = ST_ERR;
        end else if (ack_none) begin
          // The result is reported and the counters and model are updated
          // as DONE is entered. This lines them all up with the out_valid
          // cycle.
          state_d        = ST_DONE;
          out_valid_d    = 1'b1;
          out_data_d     = r_q;
          out_mismatch_d = (r_q != expected);
          tx_count_d     = tx_count_q + CNT_W'(1);
          m_d            = expected;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Rails, in_ready and err are decoded from the next state. This keeps
    // them registered but still in step with the state they describe.
    sensor_0_d = (state_d == ST_DATA) && !cap_s_d;
    sensor_1_d = (state_d == ST_DATA) &&  cap_s_d;
    start_0_d  = (state_d == ST_DATA) && !cap_t_d;
    start_1_d  = (state_d == ST_DATA) &&  cap_t_d;
    in_ready_d = (state_d == ST_IDLE) && ack_none;
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wcnt_q         <= '0;
      cap_s_q        <= 1'b0;
      cap_t_q        <= 1'b0;
      r_q            <= 1'b0;
      m_q            <= 1'b0;
      tx_count_q     <= '0;
      in_ready_q     <= 1'b0;
      sensor_0_q     <= 1'b0;
      sensor_1_q     <= 1'b0;
      start_0_q      <= 1'b0;
      start_1_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 1'b0;
      out_mismatch_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      cap_s_q        <= cap_s_d;
      cap_t_q        <= cap_t_d;
      r_q            <= r_d;
      m_q            <= m_d;
      tx_count_q     <= tx_count_d;
      in_ready_q     <= in_ready_d;
      sensor_0_q     <= sensor_0_d;
      sensor_1_q     <= sensor_1_d;
      start_0_q      <= start_0_d;
      start_1_q      <= start_1_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_mismatch_q <= out_mismatch_d;
      err_q          <= err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign sensor_0      = sensor_0_q;
  assign sensor_1      = sensor_1_q;
  assign startSignal_0 = start_0_q;
  assign startSignal_1 = start_1_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_mismatch  = out_mismatch_q;
  assign err           = err_q;
  assign tx_count      = tx_count_q;

endmodule
